// File: rtl/cpu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cpu_instr_sequencer
// Description : Feeds the 16-bit CPU with instructions from a local program
//               RAM. Each instruction word goes out on cpu_din with a single
//               cpu_run pulse, and the sequencer then waits for cpu_done.
//               Immediate-bearing instructions get the next RAM word driven
//               as the operand. Also provides start/stop control, halt-word
//               detection, a Done watchdog and a completed-instruction count.
//
// Ports       : clk, reset          - clock, synchronous active-high reset
//               start, start_addr   - begin execution (IDLE/HALT/ERR only)
//               stop                - finish current instruction, then IDLE
//               ld_we/ld_addr/ld_data - program RAM write port (not busy)
//               cpu_din, cpu_run    - registered word and run pulse to CPU
//               cpu_done            - CPU completion strobe
//               busy, halted, timeout_err - state indicators
//               pc, instr_count     - program counter, completed count
//
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_instr_sequencer #(
    parameter int          ADDR_W    = 6,
    parameter logic [15:0] HALT_WORD = 16'hFFFF,
    parameter logic [2:0]  IMM_OP    = 3'b001,
    parameter int          TIMEOUT   = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [15:0]       ld_data,
    output logic [15:0]       cpu_din,
    output logic              cpu_run,
    input  logic              cpu_done,
    output logic              busy,
    output logic              halted,
    output logic              timeout_err,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       instr_count
);

    localparam int              c_depth   = 2 ** ADDR_W;
    localparam int              c_wd_w    = $clog2(TIMEOUT + 1);
    localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);
    localparam logic [c_wd_w-1:0] c_wd_one  = c_wd_w'(1);
    localparam logic [ADDR_W-1:0] c_pc_one  = ADDR_W'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ISSUE  = 3'd3,
        S_WAIT   = 3'd4,
        S_HALT   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [15:0]         cpu_din_q, cpu_din_d;
    logic                cpu_run_q, cpu_run_d;
    logic [15:0]         instr_count_q, instr_count_d;
    logic                stop_pend_q, stop_pend_d;
    logic                imm_q, imm_d;
    logic [c_wd_w-1:0]   wd_q, wd_d;

    // Program RAM: synchronous write, registered read (one-cycle latency).
    logic [15:0]         mem [c_depth];
    logic [15:0]         mem_rd_q;
    logic [ADDR_W-1:0]   w_rd_addr;
    logic                w_busy;
    logic                w_ld_ok;

    assign w_busy  = (state_q == S_FETCH) || (state_q == S_DECODE) ||
                     (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign w_ld_ok = ld_we && !w_busy;

    // Read-before-write: a same-cycle write to the read address is not seen
    // until the following read.
    always_ff @(posedge clk) begin
        if (w_ld_ok) begin
            mem[ld_addr] <= ld_data;
        end
        mem_rd_q <= mem[w_rd_addr];
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        cpu_din_d     = cpu_din_q;
        cpu_run_d     = 1'b0;
        instr_count_d = instr_count_q;
        stop_pend_d   = stop_pend_q;
        imm_d         = imm_q;
        wd_d          = wd_q;
        w_rd_addr     = pc_q;

        // A stop request is remembered until the current instruction retires.
        if (w_busy && stop) begin
            stop_pend_d = 1'b1;
        end

        case (state_q)
            S_IDLE, S_HALT, S_ERR: begin
                if (start) begin
                    pc_d          = start_addr;
                    instr_count_d = '0;
                    stop_pend_d   = 1'b0;
                    state_d       = S_FETCH;
                end
            end

            S_FETCH: begin
                state_d = S_DECODE;
            end

            S_DECODE: begin
                if (mem_rd_q == HALT_WORD) begin
                    // pc is left pointing at the halt word.
                    state_d = S_HALT;
                end else begin
                    cpu_din_d = mem_rd_q;
                    imm_d     = (mem_rd_q[15:13] == IMM_OP);
                    // Run is registered, so it is high exactly while in ISSUE.
                    cpu_run_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end

            S_ISSUE: begin
                // Prefetch the potential immediate; it lands in the first
                // WAIT cycle.
                w_rd_addr = pc_q + c_pc_one;
                wd_d      = '0;
                state_d   = S_WAIT;
            end

            S_WAIT: begin
                wd_d = wd_q + c_wd_one;
                if ((wd_q == '0) && imm_q) begin
                    cpu_din_d = mem_rd_q;
                end
                // Done takes priority over a watchdog expiry in the same cycle.
                if (cpu_done) begin
                    pc_d          = pc_q + c_pc_one + ADDR_W'(imm_q);
                    instr_count_d = instr_count_q + 16'd1;
                    stop_pend_d   = 1'b0;
                    state_d       = (stop_pend_q || stop) ? S_IDLE : S_FETCH;
                end else if (wd_q == c_wd_last) begin
                    state_d = S_ERR;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            cpu_din_q     <= '0;
            cpu_run_q     <= 1'b0;
            instr_count_q <= '0;
            stop_pend_q   <= 1'b0;
            imm_q         <= 1'b0;
            wd_q          <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            cpu_din_q     <= cpu_din_d;
            cpu_run_q     <= cpu_run_d;
            instr_count_q <= instr_count_d;
            stop_pend_q   <= stop_pend_d;
            imm_q         <= imm_d;
            wd_q          <= wd_d;
        end
    end

    assign cpu_din     = cpu_din_q;
    assign cpu_run     = cpu_run_q;
    assign busy        = w_busy;
    assign halted      = (state_q == S_HALT);
    assign timeout_err = (state_q == S_ERR);
    assign pc          = pc_q;
    assign instr_count = instr_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_instr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_instr_sequencer
// Description : Scoreboard bench for cpu_instr_sequencer. A program-level
//               reference model walks a shadow copy of the RAM and queues the
//               expected (instruction, operand) pairs; a CPU-model/monitor
//               process pops them on each run pulse and answers with Done.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_instr_sequencer;

    localparam int          DEPTH   = 64;
    localparam int          TIMEOUT = 64;
    localparam logic [15:0] HALT    = 16'hFFFF;

    logic        clk = 1'b0;
    logic        reset, start, stop, ld_we, cpu_done;
    logic [5:0]  start_addr, ld_addr;
    logic [15:0] ld_data;
    logic [15:0] cpu_din, instr_count;
    logic        cpu_run, busy, halted, timeout_err;
    logic [5:0]  pc;

    cpu_instr_sequencer #(
        .ADDR_W    (6),
        .HALT_WORD (16'hFFFF),
        .IMM_OP    (3'b001),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .start_addr  (start_addr),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .cpu_din     (cpu_din),
        .cpu_run     (cpu_run),
        .cpu_done    (cpu_done),
        .busy        (busy),
        .halted      (halted),
        .timeout_err (timeout_err),
        .pc          (pc),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;  // word expected with the run pulse
        logic [15:0] fin;    // word expected on din when Done is given
    } exp_t;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [15:0] ref_mem [DEPTH];
    exp_t        exp_q [$];
    bit          done_en = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic bound_fail(input string nm, input int budget);
        vectors++;
        miscompares++;
        $display("FAIL %s: condition not reached, required within %0d cycles", nm, budget);
    endtask

    // Program-level model: walk the program from sa until the halt word.
    task automatic model_push(input int sa, input int max_instr, output int epc, output int ecnt);
        int   a;
        int   n;
        exp_t e;
        a = sa;
        n = 0;
        while (n < max_instr && ref_mem[a] !== HALT) begin
            e.instr = ref_mem[a];
            if (ref_mem[a][15:13] == 3'b001) begin
                e.fin = ref_mem[(a + 1) % DEPTH];
                a     = (a + 2) % DEPTH;
            end else begin
                e.fin = ref_mem[a];
                a     = (a + 1) % DEPTH;
            end
            exp_q.push_back(e);
            n++;
        end
        epc  = a;
        ecnt = n;
    endtask

    // CPU model + monitor: checks din on each run, answers Done after 2..5
    // cycles and checks the operand the CPU would capture with Done.
    initial begin : cpu_monitor
        int   cnt;
        bit   pend;
        bit   prev_run;
        exp_t cur;
        cnt      = 0;
        pend     = 1'b0;
        prev_run = 1'b0;
        cpu_done = 1'b0;
        forever begin
            @(negedge clk);
            cpu_done = 1'b0;
            if (!done_en) pend = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    chk("din_at_done", cpu_din, cur.fin);
                    cpu_done = 1'b1;
                    pend     = 1'b0;
                end
            end
            if (cpu_run) begin
                chk("run_pulse_width", prev_run, 0);
                chk("run_has_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    chk("din_at_run", cpu_din, cur.instr);
                    pend = 1'b1;
                    cnt  = $urandom_range(2, 5);
                end
            end
            prev_run = cpu_run;
        end
    end

    task automatic load(input int a, input logic [15:0] d);
        ld_we      = 1'b1;
        ld_addr    = a[5:0];
        ld_data    = d;
        ref_mem[a] = d;
        @(negedge clk);
        ld_we = 1'b0;
    endtask

    task automatic fill_halt();
        for (int i = 0; i < DEPTH; i++) load(i, HALT);
    endtask

    task automatic go(input int a);
        start      = 1'b1;
        start_addr = a[5:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_not_busy(input string nm, input int budget);
        int t;
        t = 0;
        while (busy && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (busy) bound_fail(nm, budget);
    endtask

    task automatic wait_runs(input int n, input int budget);
        int seen;
        int t;
        seen = 0;
        t    = 0;
        while (seen < n && t < budget) begin
            @(negedge clk);
            t++;
            if (cpu_run) seen++;
        end
        if (seen < n) bound_fail("wait_run", budget);
    endtask

    task automatic run_and_check(input string nm, input int sa);
        int epc;
        int ecnt;
        model_push(sa, 100, epc, ecnt);
        go(sa);
        wait_not_busy({nm, "_finish"}, 1000);
        chk({nm, "_halted"}, halted, 1);
        chk({nm, "_pc"}, pc, epc);
        chk({nm, "_count"}, instr_count, ecnt);
        chk({nm, "_err"}, timeout_err, 0);
        chk({nm, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_halted"}, halted, 0);
        chk({nm, "_err"}, timeout_err, 0);
        chk({nm, "_run"}, cpu_run, 0);
        chk({nm, "_din"}, cpu_din, 0);
        chk({nm, "_pc"}, pc, 0);
        chk({nm, "_count"}, instr_count, 0);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL global_timeout: simulation did not complete, required finish before %0t", $time);
        $fatal(1, "bench timeout");
    end

    initial begin : main
        int          epc;
        int          ecnt;
        int          sa;
        int          a;
        int          k;
        logic [15:0] w;

        reset = 1'b1; start = 1'b0; stop = 1'b0; start_addr = '0;
        ld_we = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("reset");

        fill_halt();

        // Single plain instruction; RAM[0] written in the same cycle as start.
        ld_we = 1'b1; ld_addr = 6'd0; ld_data = 16'h1234; ref_mem[0] = 16'h1234;
        model_push(0, 100, epc, ecnt);
        start = 1'b1; start_addr = 6'd0;
        @(negedge clk);
        ld_we = 1'b0; start = 1'b0;
        wait_not_busy("tc1_finish", 200);
        chk("tc1_halted", halted, 1);
        chk("tc1_pc", pc, 1);
        chk("tc1_count", instr_count, 1);
        chk("tc1_queue_left", exp_q.size(), 0);

        // Immediate-bearing instruction.
        load(4, 16'h2000); load(5, 16'h00AB); load(6, HALT);
        run_and_check("tc2", 4);
        chk("tc2_pc_abs", pc, 6);
        chk("tc2_din_imm", cpu_din, 16'h00AB);

        // pc wrap 63 -> 0.
        load(63, 16'h0111); load(0, HALT);
        run_and_check("tc3", 63);
        chk("tc3_pc_abs", pc, 0);

        // Random programs.
        for (int p = 0; p < 8; p++) begin
            fill_halt();
            sa = $urandom_range(0, 63);
            a  = sa;
            k  = $urandom_range(1, 8);
            for (int i = 0; i < k; i++) begin
                w = 16'($urandom);
                if (w == HALT) w = 16'h0000;
                if ($urandom_range(0, 2) == 0) begin
                    w[15:13] = 3'b001;
                    load(a, w);
                    load((a + 1) % DEPTH, 16'($urandom));
                    a = (a + 2) % DEPTH;
                end else begin
                    load(a, w);
                    a = (a + 1) % DEPTH;
                end
            end
            run_and_check("rand", sa);
        end

        // Watchdog: Done never given.
        load(10, 16'h4000); load(11, HALT);
        done_en = 1'b0;
        model_push(10, 1, epc, ecnt);
        go(10);
        wait_runs(1, 20);
        for (int i = 1; i <= TIMEOUT + 1; i++) begin
            @(negedge clk);
            if (i == TIMEOUT)     chk("wd_err_early", timeout_err, 0);
            if (i == TIMEOUT + 1) chk("wd_err_set", timeout_err, 1);
        end
        chk("wd_pc", pc, 10);
        chk("wd_busy", busy, 0);
        chk("wd_count", instr_count, 0);
        done_en = 1'b1;
        run_and_check("wd_restart", 10);

        // Stop during the second instruction's WAIT; write while busy ignored.
        load(20, 16'h0100); load(21, 16'h0200); load(22, 16'h0300); load(23, HALT);
        model_push(20, 2, epc, ecnt);
        go(20);
        wait_runs(2, 50);
        @(negedge clk);
        stop = 1'b1; ld_we = 1'b1; ld_addr = 6'd22; ld_data = 16'hDEAD;
        @(negedge clk);
        stop = 1'b0; ld_we = 1'b0;
        wait_not_busy("stop_finish", 100);
        chk("stop_halted", halted, 0);
        chk("stop_err", timeout_err, 0);
        chk("stop_count", instr_count, 2);
        chk("stop_pc", pc, epc);
        chk("stop_queue_left", exp_q.size(), 0);
        run_and_check("after_stop", 22);

        // Reset in mid-WAIT.
        load(30, 16'h0500); load(31, HALT);
        model_push(30, 100, epc, ecnt);
        go(30);
        wait_runs(1, 20);
        @(negedge clk);
        done_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_reset_outputs("midreset");
        exp_q.delete();
        done_en = 1'b1;
        run_and_check("after_reset", 30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
